fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the team's asynchronous FIFO among `NUM_REQ` producers in the write-clock domain. Each producer offers beats through a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wr_en`/`din` directly. It also honours the FIFO's `full` and `almost_full` flags so that no write is ever issued into a full FIFO.

---
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ producers.
// A grant lasts one burst (req_last or BURST_MAX beats); writes are gated by fifo_full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   stall_cnt
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state, next_state;
  logic [GW-1:0]   prio, next_prio, next_grant;
  logic [BW-1:0]   beats, next_beats;
  logic [15:0]     next_stall;

  // First valid requester at or after the priority pointer, wrapping.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0]      p);
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = GW'((int'(p) + k) % NUM_REQ);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] g);
    return (int'(g) == NUM_REQ - 1) ? '0 : g + GW'(1);
  endfunction

  always_comb begin
    next_state = state;
    next_grant = grant_id;
    next_prio  = prio;
    next_beats = beats;
    next_stall = stall_cnt;
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if ((|req_valid) && !fifo_almost_full && !fifo_full) begin
          next_grant = rr_pick(req_valid, prio);
          next_beats = '0;
          next_state = BURST;
        end
      end
      BURST: begin
        busy                = 1'b1;
        req_ready[grant_id] = !fifo_full;
        fifo_wr_en          = req_valid[grant_id] & !fifo_full;
        fifo_din            = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        if (req_valid[grant_id] && fifo_full) next_stall = sat_inc(stall_cnt);
        // The last beat only ends the burst once it is actually written.
        if (fifo_wr_en) begin
          next_beats = beats + BW'(1);
          if (req_last[grant_id] || (int'(beats) + 1 == BURST_MAX)) begin
            next_state = IDLE;
            next_prio  = wrap_inc(grant_id);
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      prio      <= '0;
      beats     <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= next_state;
      grant_id  <= next_grant;
      prio      <= next_prio;
      beats     <= next_beats;
      stall_cnt <= next_stall;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a behavioural arbiter model predicts writes,
// a monitor compares every cycle and pops expected beats on each DUT write.
module tb_fifo_wr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DW        = 8;
  localparam int BURST_MAX = 4;

  logic                   wr_clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic [NUM_REQ-1:0]     req_last;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   fifo_full;
  logic                   fifo_almost_full;
  logic                   fifo_wr_en;
  logic [DW-1:0]          fifo_din;
  logic [1:0]             grant_id;
  logic                   busy;
  logic [15:0]            stall_cnt;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .BURST_MAX(BURST_MAX)) dut (
    .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_almost_full(fifo_almost_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .grant_id(grant_id), .busy(busy), .stall_cnt(stall_cnt)
  );

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { int gid; logic [7:0] d; } exp_t;
  typedef struct { int gid; logic [7:0] d; int cyc; } wr_t;

  beat_t pq[NUM_REQ][$];
  exp_t  exp_q[$];
  wr_t   wlog[$];
  int    exp_g[$];
  logic [7:0] exp_d[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: who holds the grant, beats sent, priority, stalls.
  bit   m_busy  = 0;
  int   m_gid   = 0;
  int   m_prio  = 0;
  int   m_beats = 0;
  int   m_stall = 0;
  bit   found;
  logic vbit, lbit;
  logic e_busy = 0, e_wr = 0;
  logic [NUM_REQ-1:0] e_ready = '0, acc = '0;
  logic [7:0] e_din = '0;
  int   e_gid = 0, e_stall = 0;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  always @(negedge wr_clk) begin
    e_busy = 0; e_wr = 0; e_ready = '0; e_din = '0;
    e_gid = m_gid; e_stall = m_stall;
    if (rst) begin
      m_busy = 0; m_gid = 0; m_prio = 0; m_beats = 0; m_stall = 0;
      e_gid = 0; e_stall = 0;
    end else if (!m_busy) begin
      if (req_valid != '0 && !fifo_almost_full && !fifo_full) begin
        found = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && ((req_valid >> ((m_prio + k) % NUM_REQ)) & 1) != 0) begin
            found = 1;
            m_gid = (m_prio + k) % NUM_REQ;
          end
        end
        m_busy = 1; m_beats = 0;
      end
    end else begin
      vbit = req_valid[m_gid[1:0]];
      lbit = req_last[m_gid[1:0]];
      e_busy  = 1;
      e_ready = fifo_full ? '0 : (NUM_REQ'(1) << m_gid);
      e_din   = 8'(req_data >> (m_gid * DW));
      if (vbit && fifo_full) begin
        if (m_stall < 65535) m_stall++;
      end else if (vbit) begin
        e_wr = 1;
        exp_q.push_back('{m_gid, e_din});
        m_beats++;
        if (lbit || m_beats == BURST_MAX) begin
          m_busy = 0;
          m_prio = (m_gid + 1) % NUM_REQ;
        end
      end
    end
    acc = req_valid & e_ready;
  end

  always @(negedge wr_clk) begin
    #1;
    cyc++;
    chk("busy", busy, e_busy);
    chk("wr_en", fifo_wr_en, e_wr);
    chk("ready", req_ready, e_ready);
    chk("din", fifo_din, e_din);
    chk("stall_cnt", stall_cnt, e_stall);
    if (e_busy) chk("grant_id", grant_id, e_gid);
    if (fifo_wr_en) begin
      if (exp_q.size() == 0) fail_now("sb_unexpected_write");
      else begin
        mon_e = exp_q.pop_front();
        chk("sb_gid", grant_id, mon_e.gid);
        chk("sb_data", fifo_din, mon_e.d);
      end
      wlog.push_back('{int'(grant_id), fifo_din, cyc});
    end
  end

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pq[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_last[i]  = pq[i][0].l;
        req_data[i*DW +: DW] = pq[i][0].d;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    pq[i].push_back('{d, l});
    drive();
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i] && pq[i].size() > 0) pq[i].delete(0);
    drive();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_wr_en"}, fifo_wr_en, 0);
    chk({nm, "_ready"}, req_ready, 0);
    chk({nm, "_din"}, fifo_din, 0);
    chk({nm, "_grant"}, grant_id, 0);
    chk({nm, "_stall"}, stall_cnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_full = 1'b0; fifo_almost_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) pq[i].delete();
    drive();
    #1;
    check_zero("reset");
    step();
    rst = 1'b0;
    step();
    wlog.delete();
  endtask

  // A granted producer with nothing left would hold the arbiter forever, so close its burst.
  task automatic run_idle(input int max);
    int n;
    bit pend;
    n = 0;
    pend = 1;
    while (pend && n < max) begin
      if (m_busy && pq[m_gid].size() == 0) push(m_gid, 8'($urandom), 1'b1);
      step();
      n++;
      pend = m_busy;
      for (int i = 0; i < NUM_REQ; i++) if (pq[i].size() > 0) pend = 1;
    end
    if (pend) fail_now("drain_timeout");
    step();
  endtask

  task automatic wait_writes(input int cnt, input int max);
    int n;
    n = 0;
    while (wlog.size() < cnt && n < max) begin step(); n++; end
    if (wlog.size() < cnt) fail_now("write_wait_timeout");
  endtask

  task automatic check_log(input string nm, input int base);
    chk({nm, "_len"}, wlog.size() - base, exp_g.size());
    for (int k = 0; k < exp_g.size(); k++) begin
      if (base + k < wlog.size()) begin
        chk({nm, "_gid"}, wlog[base+k].gid, exp_g[k]);
        chk({nm, "_data"}, wlog[base+k].d, exp_d[k]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired: bench did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    do_reset();

    // basic burst from producer 0, then check the pointer moved past it
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    chk("basic_busy_before", busy, 0);
    step();
    chk("basic_busy_after", busy, 1);
    run_idle(50);
    exp_g = '{0, 0, 0}; exp_d = '{8'hA1, 8'hA2, 8'hA3};
    check_log("basic", 0);
    if (wlog.size() >= 3) chk("basic_consecutive", wlog[2].cyc - wlog[0].cyc, 2);
    base = wlog.size();
    push(0, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1);
    run_idle(50);
    exp_g = '{1, 0}; exp_d = '{8'hB1, 8'hB0};
    check_log("prio_after_basic", base);

    // round-robin with single-beat bursts
    do_reset();
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < NUM_REQ; i++) push(i, 8'(i*16 + n), 1'b1);
    run_idle(200);
    exp_g.delete(); exp_d.delete();
    for (int k = 0; k < 12; k++) begin
      exp_g.push_back(k % 4);
      exp_d.push_back(8'((k % 4)*16 + k/4));
    end
    check_log("rr", 0);
    for (int k = 1; k < 12; k++)
      if (k < wlog.size()) chk("rr_spacing", wlog[k].cyc - wlog[k-1].cyc, 2);

    // BURST_MAX cut: producer 2 is split around producer 3
    do_reset();
    for (int n = 0; n < 6; n++) push(2, 8'(8'h20 + n), n == 5);
    push(3, 8'h30, 1'b1);
    run_idle(100);
    exp_g = '{2, 2, 2, 2, 3, 2, 2};
    exp_d = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h24, 8'h25};
    check_log("bmax", 0);
    if (wlog.size() >= 5) chk("bmax_gap", wlog[4].cyc - wlog[3].cyc, 2);

    // full backpressure for 5 cycles mid-burst
    do_reset();
    for (int n = 0; n < 4; n++) push(1, 8'(8'h40 + n), n == 3);
    wait_writes(2, 20);
    fifo_full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("full_wr_en", fifo_wr_en, 0);
      chk("full_ready", req_ready, 0);
    end
    fifo_full = 1'b0;
    run_idle(50);
    chk("full_stall_cnt", stall_cnt, 5);
    exp_g = '{1, 1, 1, 1}; exp_d = '{8'h40, 8'h41, 8'h42, 8'h43};
    check_log("full", 0);

    // almost_full blocks a new grant only
    do_reset();
    fifo_almost_full = 1'b1;
    push(1, 8'h50, 1'b1);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("afull_no_grant", busy, 0);
    end
    fifo_almost_full = 1'b0;
    step();
    chk("afull_grant", busy, 1);
    chk("afull_gid", grant_id, 1);
    run_idle(50);
    exp_g = '{1}; exp_d = '{8'h50};
    check_log("afull", 0);

    // reset in the middle of a 4-beat burst
    do_reset();
    for (int n = 0; n < 4; n++) push(2, 8'(8'h60 + n), n == 3);
    wait_writes(2, 20);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    step();
    rst = 1'b0;
    base = wlog.size();
    push(0, 8'h70, 1'b1);
    run_idle(50);
    exp_g = '{0, 2, 2}; exp_d = '{8'h70, 8'h62, 8'h63};
    check_log("midrst_after", base);

    // randomized traffic with random full/almost_full
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(3) == 0 && pq[i].size() < 6)
          push(i, 8'($urandom), $urandom_range(2) == 0);
      fifo_full        = ($urandom_range(5) == 0);
      fifo_almost_full = ($urandom_range(3) == 0);
      step();
    end
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    run_idle(500);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
